// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Holds the funct3 load/store encodings, FSM states, byte-enable constants and the legality check.
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_type_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam logic [3:0] BE_B0  = 4'b0001;
   localparam logic [3:0] BE_LO  = 4'b0011;
   localparam logic [3:0] BE_HI  = 4'b1100;
   localparam logic [3:0] BE_ALL = 4'b1111;

   // Unsigned variants exist only for loads, so a store with funct3[2] set is rejected.
   function automatic logic accessIllegal(input logic re, input logic we,
                                          input logic [2:0] memType, input logic [1:0] off);
      logic bad;
      bad = (re & we) | (we & memType[2]);
      case (memType)
         MEM_B, MEM_BU:  bad = bad;
         MEM_H, MEM_HU:  bad = bad | off[0];
         MEM_W:          bad = bad | (off != 2'b00);
         default:        bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core and a 32-bit word bus.
// The load path extracts and extends the addressed field; the store path builds strobes and replicated data.
module mem_lane_align
   import mem_ctrl_pkg::*;
(
   input  logic [2:0]  ld_type_i,
   input  logic [1:0]  ld_offset_i,
   input  logic [31:0] ld_word_i,
   output logic [31:0] ld_data_o,
   input  logic [2:0]  st_type_i,
   input  logic [1:0]  st_offset_i,
   input  logic [31:0] st_data_i,
   output logic [3:0]  st_be_o,
   output logic [31:0] st_wdata_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted = ld_word_i >> {ld_offset_i, 3'b000};
      case (ld_type_i)
         MEM_B:   ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
         MEM_H:   ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
         MEM_BU:  ld_data_o = {24'h000000, shifted[7:0]};
         MEM_HU:  ld_data_o = {16'h0000, shifted[15:0]};
         default: ld_data_o = shifted;
      endcase
   end

   // Replicating the data lets the memory pick the lane from the strobes alone.
   always_comb begin
      case (st_type_i)
         MEM_B: begin
            st_be_o    = BE_B0 << st_offset_i;
            st_wdata_o = {4{st_data_i[7:0]}};
         end
         MEM_H: begin
            st_be_o    = st_offset_i[1] ? BE_HI : BE_LO;
            st_wdata_o = {2{st_data_i[15:0]}};
         end
         default: begin
            st_be_o    = BE_ALL;
            st_wdata_o = st_data_i;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Sequences core loads/stores onto a req/gnt/rvalid bus and stalls the core until each access
// finishes, faults on misalignment, or is abandoned after TIMEOUT cycles on the bus.
module data_mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_enable_i,
   input  logic              write_enable_i,
   input  logic [2:0]        mem_type_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [31:0]       rdata_o,
   output logic              mis_err_o,
   output logic              tout_err_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_be_o,
   output logic [31:0]       bus_wdata_o,
   input  logic              bus_gnt_i,
   input  logic              bus_rvalid_i,
   input  logic [31:0]       bus_rdata_i
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e              state_q;
   logic [CNT_W-1:0]    toutCnt_q;
   logic [CNT_W-1:0]    toutCnt_d;
   logic                timeoutHit;
   logic                busReq_q;
   logic                busWe_q;
   logic [ADDR_W-1:0]   busAddr_q;
   logic [3:0]          busBe_q;
   logic [31:0]         busWdata_q;
   logic [2:0]          ldType_q;
   logic [1:0]          ldOff_q;
   logic [31:0]         rdata_q;
   logic                done_q;
   logic                misErr_q;
   logic                toutErr_q;
   logic [31:0]         ldData;
   logic [3:0]          stBe;
   logic [31:0]         stWdata;
   logic                accessReq;

   mem_lane_align u_lane (
      .ld_type_i   (ldType_q),
      .ld_offset_i (ldOff_q),
      .ld_word_i   (bus_rdata_i),
      .ld_data_o   (ldData),
      .st_type_i   (mem_type_i),
      .st_offset_i (addr_i[1:0]),
      .st_data_i   (wdata_i),
      .st_be_o     (stBe),
      .st_wdata_o  (stWdata)
   );

   assign accessReq  = read_enable_i | write_enable_i;
   assign toutCnt_d  = toutCnt_q + CNT_W'(1);
   assign timeoutHit = (toutCnt_d == CNT_W'(TIMEOUT));

   // Completion on the final allowed cycle takes priority over the timeout abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         toutCnt_q  <= '0;
         busReq_q   <= 1'b0;
         busWe_q    <= 1'b0;
         busAddr_q  <= '0;
         busBe_q    <= '0;
         busWdata_q <= '0;
         ldType_q   <= '0;
         ldOff_q    <= '0;
         rdata_q    <= '0;
         done_q     <= 1'b0;
         misErr_q   <= 1'b0;
         toutErr_q  <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         misErr_q  <= 1'b0;
         toutErr_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accessReq) begin
                  if (accessIllegal(read_enable_i, write_enable_i, mem_type_i, addr_i[1:0])) begin
                     state_q  <= ST_ERR;
                     misErr_q <= 1'b1;
                     rdata_q  <= '0;
                  end else begin
                     state_q    <= ST_REQ;
                     toutCnt_q  <= '0;
                     busReq_q   <= 1'b1;
                     busWe_q    <= write_enable_i;
                     busAddr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                     busBe_q    <= write_enable_i ? stBe : BE_ALL;
                     busWdata_q <= write_enable_i ? stWdata : '0;
                     ldType_q   <= mem_type_i;
                     ldOff_q    <= addr_i[1:0];
                  end
               end
            end
            ST_REQ: begin
               if (bus_gnt_i && (busWe_q || bus_rvalid_i)) begin
                  busReq_q <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
                  if (!busWe_q) begin
                     rdata_q <= ldData;
                  end
               end else if (timeoutHit) begin
                  busReq_q  <= 1'b0;
                  toutErr_q <= 1'b1;
                  rdata_q   <= '0;
                  state_q   <= ST_ERR;
               end else begin
                  toutCnt_q <= toutCnt_d;
                  if (bus_gnt_i) begin
                     busReq_q <= 1'b0;
                     state_q  <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (bus_rvalid_i) begin
                  rdata_q <= ldData;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (timeoutHit) begin
                  toutErr_q <= 1'b1;
                  rdata_q   <= '0;
                  state_q   <= ST_ERR;
               end else begin
                  toutCnt_q <= toutCnt_d;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            ST_ERR:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Reset forces the stall low even while the core still presents a request.
   assign stall_o = !rst && (((state_q == ST_IDLE) && accessReq) ||
                             (state_q == ST_REQ) || (state_q == ST_WAIT));

   assign done_o      = done_q;
   assign mis_err_o   = misErr_q;
   assign tout_err_o  = toutErr_q;
   assign rdata_o     = rdata_q;
   assign bus_req_o   = busReq_q;
   assign bus_we_o    = busWe_q;
   assign bus_addr_o  = busAddr_q;
   assign bus_be_o    = busBe_q;
   assign bus_wdata_o = busWdata_q;

endmodule
